// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between
// the Core and the debug/monitor port, with a saturating conflict counter.
module ram_arbiter #(
    parameter int AddrWidth = 9,
    parameter int DataWidth = 8,
    parameter int CntWidth  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c_req,
    input  logic                 c_we,
    input  logic [AddrWidth-1:0] c_addr,
    input  logic [DataWidth-1:0] c_wdata,
    output logic                 c_gnt,
    output logic                 c_rvalid,
    output logic [DataWidth-1:0] c_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [AddrWidth-1:0] d_addr,
    input  logic [DataWidth-1:0] d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [DataWidth-1:0] d_rdata,
    output logic [AddrWidth-1:0] m_addr,
    output logic [DataWidth-1:0] m_wdata,
    output logic                 m_we,
    input  logic [DataWidth-1:0] m_rdata,
    output logic [CntWidth-1:0]  conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    logic   last_dbg;
    logic   owner_dbg;
    logic   acc_we;
    logic   pick_dbg;
    logic   tie;

    // Debug wins when alone, or on a tie when the Core went last.
    always_comb begin
        tie      = c_req && d_req;
        pick_dbg = d_req && (!c_req || !last_dbg);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            last_dbg     <= 1'b1;
            owner_dbg    <= 1'b0;
            acc_we       <= 1'b0;
            c_gnt        <= 1'b0;
            c_rvalid     <= 1'b0;
            c_rdata      <= '0;
            d_gnt        <= 1'b0;
            d_rvalid     <= 1'b0;
            d_rdata      <= '0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_we         <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            c_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    m_we <= 1'b0;
                    if (c_req || d_req) begin
                        owner_dbg <= pick_dbg;
                        last_dbg  <= pick_dbg;
                        m_addr    <= pick_dbg ? d_addr : c_addr;
                        m_wdata   <= pick_dbg ? d_wdata : c_wdata;
                        m_we      <= pick_dbg ? d_we : c_we;
                        acc_we    <= pick_dbg ? d_we : c_we;
                        d_gnt     <= pick_dbg;
                        c_gnt     <= !pick_dbg;
                        if (tie && conflict_cnt != '1)
                            conflict_cnt <= conflict_cnt + 1'b1;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    m_we  <= 1'b0;
                    state <= RESP;
                end
                RESP: begin
                    m_we <= 1'b0;
                    if (owner_dbg) begin
                        d_rvalid <= 1'b1;
                        if (!acc_we)
                            d_rdata <= m_rdata;
                    end else begin
                        c_rvalid <= 1'b1;
                        if (!acc_we)
                            c_rdata <= m_rdata;
                    end
                    state <= IDLE;
                end
                default: begin
                    m_we  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester arbiter that shares the single-port synchronous RAM between the Core and a debug/monitor port. The monitor is driven from the debounced buttons and reads or pokes memory for the seven-segment display. The block sits between both requesters and the RAM instance, and owns the RAM addr/wdata/we nets. Each granted access runs a fixed 3-cycle sequence with round-robin fairness, plus a saturating conflict counter for display.

Parameters:
AddrWidth, 9, RAM address width
DataWidth, 8, RAM data width
CntWidth, 16, width of the conflict counter

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset
c_req  input  1  Core request; addr/we/wdata held stable while high
c_we  input  1  Core write enable (1 = write, 0 = read)
c_addr  input  AddrWidth  Core address
c_wdata  input  DataWidth  Core write data
c_gnt  output  1  one-cycle pulse: Core access in progress
c_rvalid  output  1  one-cycle pulse: Core access complete
c_rdata  output  DataWidth  Core read data, valid with c_rvalid, held after
d_req, d_we, d_addr, d_wdata  input  1/1/AddrWidth/DataWidth  debug request port, same rules as the Core port
d_gnt, d_rvalid  output  1  debug grant / completion pulses
d_rdata  output  DataWidth  debug read data
m_addr  output  AddrWidth  RAM address (registered)
m_wdata  output  DataWidth  RAM write data (registered)
m_we  output  1  RAM write enable (registered)
m_rdata  input  DataWidth  RAM read data, valid the cycle after the RAM edge that sampled m_addr
conflict_cnt  output  CntWidth  count of cycles in which a requester lost arbitration

Behaviour:
- Reset (reset==0 at posedge): state=IDLE. All outputs 0, including c_rdata, d_rdata, m_* and conflict_cnt. last_owner=DBG, so the Core wins the first tie.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Every transition is unconditional except leaving IDLE.
- IDLE (cycle T):
  - Sample c_req/d_req.
  - Neither high: stay in IDLE, m_we=0.
  - Exactly one high: that port becomes owner.
  - Both high: owner = the port that is not last_owner; conflict_cnt += 1, saturating at all-ones.
  - On leaving IDLE: latch the owner's addr/wdata/we into m_addr/m_wdata/m_we, set last_owner=owner, go to ACCESS.
- ACCESS (T+1):
  - Owner's gnt=1 for this cycle only.
  - m_* stable; the RAM performs the write or read at the end of T+1.
  - The requester may drop req or change addr/we/wdata from T+2 onward.
- RESP (T+2):
  - m_we=0; m_addr held.
  - Read: capture m_rdata into the owner's rdata register at the end of T+2.
  - Write: the rdata register is unchanged.
- T+3: owner's rvalid=1 for one cycle; state=IDLE, so a new arbitration happens in the same cycle.
- Throughput: at most one access per 3 cycles. Read latency from req sampled to rvalid is 3 cycles.
- A req still high in a later IDLE cycle is a new access. Holding req continuously therefore yields back-to-back accesses every 3 cycles.
- A continuous tie alternates owners: C, D, C, D...
- The non-owner port sees gnt=0 and rvalid=0 throughout.
- Outside ACCESS, m_we is 0. m_addr/m_wdata hold their last values while idle.
- Reset mid-operation: the next edge forces IDLE and m_we=0, and all rdata registers clear to 0. No rvalid is issued for the aborted access. A write whose ACCESS edge coincides with the reset edge is not guaranteed to have committed.
- conflict_cnt never wraps. It clears only on reset.

Test Plan:
- Core read alone: RAM[0x0A]=0x5C, c_req=1, c_we=0, c_addr=0x0A at T -> c_gnt at T+1, m_addr=0x0A at T+1, c_rvalid and c_rdata=0x5C at T+3; d_* outputs stay 0.
- Debug write then Core read: d write 0x1F3<-0xA5, then c read 0x1F3 -> m_we=1 only in d's ACCESS cycle, d_rvalid pulses, c_rdata=0xA5, d_rdata unchanged (0).
- Tie after reset: c_req and d_req rise together and stay held -> grant order C, D, C, D with gnt pulses 3 cycles apart; conflict_cnt=1,2,3,4 after each tie arbitration.
- Back-to-back: c_req held for 9 cycles, addr stepping 0,1,2 on each gnt -> exactly 3 c_rvalid pulses with data RAM[0..2]; m_we stays 0.
- Reset mid-ACCESS: assert reset=0 during a Core write's ACCESS cycle -> next cycle state=IDLE, m_we=0, c_rvalid never pulses, conflict_cnt=0, and a new request after release is serviced normally.
- Saturation (CntWidth=2 override): 5 tie arbitrations -> conflict_cnt reads 1,2,3,3,3.
